// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared geometry, FSM encodings and helpers for the OLED text scheduler
package oled_pkg;

  localparam int OLED_ROWS = 4;
  localparam int OLED_COLS = 16;
  localparam int CELL_W    = 6;
  localparam int ADDR_W    = 9;
  localparam int NUM_CELLS = OLED_ROWS * OLED_COLS;

  localparam logic [7:0] BLANK_CHAR_DEF = 8'h20;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SCAN      = 3'd1;
  localparam logic [2:0] ST_WR_ISSUE  = 3'd2;
  localparam logic [2:0] ST_WR_WAIT   = 3'd3;
  localparam logic [2:0] ST_UPD_ISSUE = 3'd4;
  localparam logic [2:0] ST_UPD_WAIT  = 3'd5;
  localparam logic [2:0] ST_CLR_FILL  = 3'd6;
  localparam logic [2:0] ST_CLR_ISSUE = 3'd7;

  typedef logic [CELL_W-1:0] cell_idx_t;

  // OLEDCtrl addresses a cell by its first pixel row, 8 rows per character.
  function automatic logic [ADDR_W-1:0] cell_addr(input cell_idx_t idx);
    return {idx, 3'b000};
  endfunction

endpackage

// File: rtl/oled_shadow_ram.sv
// rtl/oled_shadow_ram.sv - 64x8 shadow character store with per-cell dirty bitmap
module oled_shadow_ram
  import oled_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       host_we_i,
  input  cell_idx_t  host_idx_i,
  input  logic [7:0] host_data_i,
  input  logic       fill_we_i,
  input  cell_idx_t  fill_idx_i,
  input  logic [7:0] fill_data_i,
  input  logic       clr_one_i,
  input  cell_idx_t  clr_idx_i,
  input  logic       clr_all_i,
  input  cell_idx_t  rd_idx_i,
  output logic [7:0] rd_data_o,
  output logic       rd_dirty_o
);

  logic [7:0]           mem_q [NUM_CELLS];
  logic [NUM_CELLS-1:0] dirty_q;
  logic [NUM_CELLS-1:0] dirty_d;

  always_ff @(posedge clk_i) begin
    if (fill_we_i) begin
      mem_q[fill_idx_i] <= fill_data_i;
    end else if (host_we_i) begin
      mem_q[host_idx_i] <= host_data_i;
    end
  end

  // A host write landing on the cell being retired keeps it dirty.
  always_comb begin
    dirty_d = dirty_q;
    if (clr_all_i) dirty_d = '0;
    if (clr_one_i) dirty_d[clr_idx_i] = 1'b0;
    if (host_we_i) dirty_d[host_idx_i] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dirty_q <= '0;
    end else begin
      dirty_q <= dirty_d;
    end
  end

  assign rd_data_o  = mem_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];

endmodule

// File: rtl/oled_text_scheduler.sv
// rtl/oled_text_scheduler.sv - streams dirty shadow cells to OLEDCtrl and batches display updates
module oled_text_scheduler
  import oled_pkg::*;
#(
  parameter bit         AUTO_UPDATE = 1'b1,
  parameter logic [7:0] BLANK_CHAR  = BLANK_CHAR_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              oled_on_i,
  input  logic              host_we_i,
  input  logic [1:0]        host_row_i,
  input  logic [3:0]        host_col_i,
  input  logic [7:0]        host_char_i,
  input  logic              flush_req_i,
  input  logic              clear_req_i,
  output logic              write_start_o,
  output logic [7:0]        write_ascii_data_o,
  output logic [ADDR_W-1:0] write_base_addr_o,
  input  logic              write_ready_i,
  output logic              update_start_o,
  output logic              update_clear_o,
  input  logic              update_ready_i,
  output logic              busy_o
);

  logic [2:0]        state_q, state_d;
  cell_idx_t         ptr_q, ptr_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              pending_q, pending_d;
  logic              flush_pend_q, flush_pend_d;
  logic              clear_pend_q, clear_pend_d;
  logic              from_reset_q, from_reset_d;
  logic              seen_low_q, seen_low_d;
  logic [7:0]        data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              upd_clear_q, upd_clear_d;

  logic       host_we_ok;
  logic       clr_one, clr_all, fill_we;
  logic [7:0] rd_data;
  logic       rd_dirty;
  logic       wait_rdy;
  logic       upd_want;

  assign host_we_ok = host_we_i && (state_q != ST_CLR_FILL);
  assign wait_rdy   = (state_q == ST_WR_WAIT) ? write_ready_i : update_ready_i;
  assign upd_want   = (pending_q && AUTO_UPDATE) || flush_pend_q;

  oled_shadow_ram u_ram (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .host_we_i   (host_we_ok),
    .host_idx_i  ({host_row_i, host_col_i}),
    .host_data_i (host_char_i),
    .fill_we_i   (fill_we),
    .fill_idx_i  (cnt_q),
    .fill_data_i (BLANK_CHAR),
    .clr_one_i   (clr_one),
    .clr_idx_i   (ptr_q),
    .clr_all_i   (clr_all),
    .rd_idx_i    (ptr_q),
    .rd_data_o   (rd_data),
    .rd_dirty_o  (rd_dirty)
  );

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    flush_pend_d = flush_pend_q;
    clear_pend_d = clear_pend_q;
    from_reset_d = from_reset_q;
    seen_low_d   = seen_low_q;
    data_d       = data_q;
    addr_d       = addr_q;
    upd_clear_d  = upd_clear_q;
    clr_one      = 1'b0;
    clr_all      = 1'b0;
    fill_we      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (oled_on_i) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (clear_pend_q) begin
          state_d = ST_CLR_FILL;
          cnt_d   = '0;
        end else if (rd_dirty && write_ready_i) begin
          state_d = ST_WR_ISSUE;
        end else begin
          ptr_d = ptr_q + 6'd1;
          // cnt saturates at 63 so a clean display re-polls the update condition every cycle
          if (rd_dirty) begin
            cnt_d = '0;
          end else if (cnt_q != 6'd63) begin
            cnt_d = cnt_q + 6'd1;
          end else if (upd_want && update_ready_i) begin
            state_d = ST_UPD_ISSUE;
          end
        end
      end
      ST_WR_ISSUE: begin
        data_d     = rd_data;
        addr_d     = cell_addr(ptr_q);
        clr_one    = 1'b1;
        pending_d  = 1'b1;
        seen_low_d = 1'b0;
        cnt_d      = '0;
        state_d    = ST_WR_WAIT;
      end
      ST_WR_WAIT, ST_UPD_WAIT: begin
        if (!wait_rdy) seen_low_d = 1'b1;
        if (seen_low_q && wait_rdy) begin
          state_d = ST_SCAN;
          if (state_q == ST_WR_WAIT) ptr_d = ptr_q + 6'd1;
        end
      end
      ST_UPD_ISSUE: begin
        pending_d    = 1'b0;
        flush_pend_d = 1'b0;
        upd_clear_d  = 1'b0;
        seen_low_d   = 1'b0;
        state_d      = ST_UPD_WAIT;
      end
      ST_CLR_FILL: begin
        fill_we = 1'b1;
        clr_all = 1'b1;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d      = from_reset_q ? ST_SCAN : ST_CLR_ISSUE;
          from_reset_d = 1'b0;
        end
      end
      ST_CLR_ISSUE: begin
        if (update_ready_i) begin
          upd_clear_d  = 1'b1;
          clear_pend_d = 1'b0;
          pending_d    = 1'b0;
          seen_low_d   = 1'b0;
          state_d      = ST_UPD_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (host_we_ok) cnt_d = '0;
    // The blanking fill is internal to the shadow and always runs to completion.
    if (!oled_on_i && state_q != ST_CLR_FILL) state_d = ST_IDLE;
    flush_pend_d = flush_pend_d | flush_req_i;
    clear_pend_d = clear_pend_d | clear_req_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_CLR_FILL;
      ptr_q        <= '0;
      cnt_q        <= '0;
      pending_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      clear_pend_q <= 1'b0;
      from_reset_q <= 1'b1;
      seen_low_q   <= 1'b0;
      data_q       <= '0;
      addr_q       <= '0;
      upd_clear_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      pending_q    <= pending_d;
      flush_pend_q <= flush_pend_d;
      clear_pend_q <= clear_pend_d;
      from_reset_q <= from_reset_d;
      seen_low_q   <= seen_low_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      upd_clear_q  <= upd_clear_d;
    end
  end

  assign write_start_o      = (state_q == ST_WR_ISSUE);
  assign write_ascii_data_o = (state_q == ST_WR_ISSUE) ? rd_data : data_q;
  assign write_base_addr_o  = (state_q == ST_WR_ISSUE) ? cell_addr(ptr_q) : addr_q;
  assign update_start_o     = (state_q == ST_UPD_ISSUE) ||
                              ((state_q == ST_CLR_ISSUE) && update_ready_i);
  assign update_clear_o     = (state_q == ST_UPD_ISSUE) ? 1'b0 :
                              ((state_q == ST_CLR_ISSUE) && update_ready_i) ? 1'b1 :
                              upd_clear_q;
  assign busy_o             = (state_q != ST_IDLE) && (state_q != ST_SCAN);

endmodule

// File: tb/tb_oled_text_scheduler.sv
// tb/tb_oled_text_scheduler.sv - scoreboard bench for the OLED text scheduler with an OLEDCtrl responder
module tb_oled_text_scheduler;
  import oled_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, oled_on, host_we, flush_req, clear_req, wr_rdy, up_rdy;
  logic [1:0] host_row;
  logic [3:0] host_col;
  logic [7:0] host_char, wdata;
  logic [8:0] waddr;
  logic write_start, update_start, update_clear, busy;

  logic z_oled_on, z_we, z_flush, z_wr_rdy, z_up_rdy;
  logic [1:0] z_row;
  logic [3:0] z_col;
  logic [7:0] z_char, z_wdata;
  logic [8:0] z_waddr;
  logic z_write_start, z_update_start, z_update_clear, z_busy;

  oled_text_scheduler dut (
    .clk_i(clk), .rst_i(rst), .oled_on_i(oled_on), .host_we_i(host_we),
    .host_row_i(host_row), .host_col_i(host_col), .host_char_i(host_char),
    .flush_req_i(flush_req), .clear_req_i(clear_req),
    .write_start_o(write_start), .write_ascii_data_o(wdata), .write_base_addr_o(waddr),
    .write_ready_i(wr_rdy), .update_start_o(update_start), .update_clear_o(update_clear),
    .update_ready_i(up_rdy), .busy_o(busy)
  );

  oled_text_scheduler #(.AUTO_UPDATE(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .oled_on_i(z_oled_on), .host_we_i(z_we),
    .host_row_i(z_row), .host_col_i(z_col), .host_char_i(z_char),
    .flush_req_i(z_flush), .clear_req_i(1'b0),
    .write_start_o(z_write_start), .write_ascii_data_o(z_wdata), .write_base_addr_o(z_waddr),
    .write_ready_i(z_wr_rdy), .update_start_o(z_update_start), .update_clear_o(z_update_clear),
    .update_ready_i(z_up_rdy), .busy_o(z_busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: {char, addr} per expected write, update_clear per expected update.
  logic [16:0] wq[$];
  logic        uq[$];
  int n_wr = 0, n_upd = 0, wr_cnt = 0, up_cnt = 0, hit;

  always @(negedge clk) begin
    if (write_start) begin
      check("wr_ready_at_start", 32'(wr_rdy), 1);
      n_wr++;
      hit = -1;
      for (int i = 0; i < wq.size(); i++)
        if (hit < 0 && wq[i][8:0] == waddr) hit = i;
      check("wr_addr_expected", 32'(hit >= 0), 1);
      if (hit >= 0) begin
        check("wr_data", 32'(wdata), 32'(wq[hit][16:9]));
        wq.delete(hit);
      end
      wr_rdy = 1'b0;
      wr_cnt = 3;
    end else if (wr_cnt > 0) begin
      wr_cnt--;
      if (wr_cnt == 0) wr_rdy = 1'b1;
    end
    if (update_start) begin
      check("upd_ready_at_start", 32'(up_rdy), 1);
      n_upd++;
      check("upd_after_writes", wq.size(), 0);
      if (uq.size() == 0) check("upd_expected", 0, 1);
      else check("upd_clear", 32'(update_clear), 32'(uq.pop_front()));
      up_rdy = 1'b0;
      up_cnt = 4;
    end else if (up_cnt > 0) begin
      up_cnt--;
      if (up_cnt == 0) up_rdy = 1'b1;
    end
  end

  int z_n_wr = 0, z_n_upd = 0, z_wr_cnt = 0, z_up_cnt = 0;
  logic [7:0] z_last_data = '0;
  logic [8:0] z_last_addr = '0;
  logic       z_last_clr = 1'b1;

  always @(negedge clk) begin
    if (z_write_start) begin
      z_n_wr++;
      z_last_data = z_wdata;
      z_last_addr = z_waddr;
      z_wr_rdy = 1'b0;
      z_wr_cnt = 3;
    end else if (z_wr_cnt > 0) begin
      z_wr_cnt--;
      if (z_wr_cnt == 0) z_wr_rdy = 1'b1;
    end
    if (z_update_start) begin
      z_n_upd++;
      z_last_clr = z_update_clear;
      z_up_rdy = 1'b0;
      z_up_cnt = 4;
    end else if (z_up_cnt > 0) begin
      z_up_cnt--;
      if (z_up_cnt == 0) z_up_rdy = 1'b1;
    end
  end

  task automatic host_write(input logic [1:0] r, input logic [3:0] c, input logic [7:0] ch);
    host_we = 1'b1; host_row = r; host_col = c; host_char = ch;
    wq.push_back({ch, r, c, 3'b000});
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic z_write(input logic [1:0] r, input logic [3:0] c, input logic [7:0] ch);
    z_we = 1'b1; z_row = r; z_col = c; z_char = ch;
    @(negedge clk);
    z_we = 1'b0;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((wq.size() != 0 || uq.size() != 0) && k < 800) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, wq.size() + uq.size(), 0);
    repeat (150) @(negedge clk);
  endtask

  task automatic wait_write(input string tag, input logic [8:0] a);
    int k;
    k = 0;
    while (!(write_start && waddr == a) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_seen"}, 32'(write_start && waddr == a), 1);
  endtask

  task automatic check_blank(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (dut.u_ram.mem_q[i] != 8'h20) bad++;
    check({tag, "_nonblank_cells"}, bad, 0);
  endtask

  int w0, u0, lat;

  initial begin
    rst = 1'b1; oled_on = 1'b1; host_we = 1'b0; host_row = '0; host_col = '0; host_char = '0;
    flush_req = 1'b0; clear_req = 1'b0; wr_rdy = 1'b1; up_rdy = 1'b1;
    z_oled_on = 1'b1; z_we = 1'b0; z_row = '0; z_col = '0; z_char = '0; z_flush = 1'b0;
    z_wr_rdy = 1'b1; z_up_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_write_start", 32'(write_start), 0);
    check("rst_update_start", 32'(update_start), 0);
    check("rst_update_clear", 32'(update_clear), 0);
    check("rst_waddr", 32'(waddr), 0);
    check("rst_wdata", 32'(wdata), 0);
    rst = 1'b0;

    repeat (1000) @(negedge clk);
    check("quiet_writes", n_wr, 0);
    check("quiet_updates", n_upd, 0);
    check("quiet_busy", 32'(busy), 0);
    check("quiet_dirty", 32'(dut.u_ram.dirty_q == 64'd0), 1);
    check_blank("reset");

    w0 = n_wr; u0 = n_upd;
    uq.push_back(1'b0);
    host_write(2'd1, 4'd2, 8'h41);
    lat = 1;
    while (!write_start && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check("wr_latency_le65", 32'(lat <= 65), 1);
    check("wr_addr_cell_1_2", 32'(waddr), 32'h090);
    check("wr_data_cell_1_2", 32'(wdata), 32'h41);
    drain("single");
    check("single_writes", n_wr - w0, 1);
    check("single_updates", n_upd - u0, 1);
    check("single_update_clear", 32'(update_clear), 0);

    w0 = n_wr; u0 = n_upd;
    uq.push_back(1'b0);
    host_write(2'd0, 4'd0, 8'h78);
    host_write(2'd3, 4'd15, 8'h79);
    drain("corners");
    check("corners_writes", n_wr - w0, 2);
    check("corners_updates", n_upd - u0, 1);

    w0 = n_wr; u0 = n_upd;
    uq.push_back(1'b0);
    host_write(2'd0, 4'd5, 8'h41);
    wait_write("race_A", 9'h028);
    host_write(2'd0, 4'd5, 8'h42);
    drain("race");
    check("race_writes", n_wr - w0, 2);
    check("race_updates", n_upd - u0, 1);
    check("race_dirty_zero", 32'(dut.u_ram.dirty_q == 64'd0), 1);
    check("race_cell5", 32'(dut.u_ram.mem_q[5]), 32'h42);

    w0 = n_wr; u0 = n_upd;
    host_write(2'd0, 4'd10, 8'h51);
    wait_write("clr_Q", 9'h050);
    @(negedge clk);
    check("clr_busy_in_wait", 32'(busy), 1);
    uq.push_back(1'b1);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    drain("clear");
    check("clear_writes", n_wr - w0, 1);
    check("clear_updates", n_upd - u0, 1);
    check("clear_update_clear_held", 32'(update_clear), 1);
    check("clear_dirty_zero", 32'(dut.u_ram.dirty_q == 64'd0), 1);
    check_blank("clear");

    w0 = z_n_wr; u0 = z_n_upd;
    z_write(2'd0, 4'd0, 8'h5A);
    repeat (300) @(negedge clk);
    check("noauto_writes", z_n_wr - w0, 1);
    check("noauto_data", 32'(z_last_data), 32'h5A);
    check("noauto_addr", 32'(z_last_addr), 32'h000);
    check("noauto_no_update", z_n_upd - u0, 0);
    z_flush = 1'b1;
    @(negedge clk);
    z_flush = 1'b0;
    repeat (200) @(negedge clk);
    check("flush_updates", z_n_upd - u0, 1);
    check("flush_update_clear", 32'(z_last_clr), 0);

    w0 = z_n_wr; u0 = z_n_upd;
    z_oled_on = 1'b0;
    @(negedge clk);
    z_write(2'd0, 4'd1, 8'h59);
    z_flush = 1'b1;
    @(negedge clk);
    z_flush = 1'b0;
    repeat (200) @(negedge clk);
    check("off_writes", z_n_wr - w0, 0);
    check("off_updates", z_n_upd - u0, 0);
    check("off_busy", 32'(z_busy), 0);
    check("off_state_idle", 32'(dut0.state_q), 32'(ST_IDLE));
    z_oled_on = 1'b1;
    repeat (300) @(negedge clk);
    check("on_writes", z_n_wr - w0, 1);
    check("on_data", 32'(z_last_data), 32'h59);
    check("on_addr", 32'(z_last_addr), 32'h008);
    check("on_updates", z_n_upd - u0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
